// File: rtl/mc_pkg.sv
// mc_pkg: opcodes, FSM states, ALU-op and condition encodings for mc_datapath_p
package mc_pkg;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4, OP_SLT = 4'h5, OP_ADDI = 4'h6, OP_LW = 4'h8;
  localparam logic [3:0] OP_SW = 4'h9, OP_BEQ = 4'hC, OP_JAL = 4'hD, OP_HALT = 4'hF;
  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMRD, S_MEMWB, S_MEMWR, S_HALT
  } state_t;
  // R-type opcodes carry their ALU operation in the low three bits
  localparam logic [2:0] ALU_ADD = OP_ADD[2:0], ALU_SUB = OP_SUB[2:0], ALU_AND = OP_AND[2:0];
  localparam logic [2:0] ALU_OR = OP_OR[2:0], ALU_XOR = OP_XOR[2:0], ALU_SLT = OP_SLT[2:0];
  localparam logic [1:0] COND_AL = 2'd0, COND_Z = 2'd1, COND_C = 2'd2, COND_NZ = 2'd3;
  function automatic logic is_rtype(input logic [3:0] op);
    return op <= OP_SLT;
  endfunction
endpackage

// File: rtl/mc_alu.sv
// mc_alu: combinational ALU with zero flag and carry/no-borrow flag
module mc_alu import mc_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       aluop,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);
  logic [WIDTH:0] sum, diff;
  logic           lt;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign lt   = $signed(a) < $signed(b);
  always_comb begin
    result = aluop == ALU_ADD ? sum[WIDTH-1:0] :
             aluop == ALU_SUB ? diff[WIDTH-1:0] :
             aluop == ALU_AND ? a & b :
             aluop == ALU_OR  ? a | b :
             aluop == ALU_XOR ? a ^ b :
             aluop == ALU_SLT ? {{(WIDTH-1){1'b0}}, lt} : '0;
    carry  = aluop == ALU_ADD ? sum[WIDTH] : aluop == ALU_SUB ? ~diff[WIDTH] : 1'b0;
  end
  assign zero = result == '0;
endmodule

// File: rtl/mc_datapath_p.sv
// mc_datapath_p: multicycle 16-bit-instruction core with shared memory handshake,
// registered flags, conditional writeback, link calls, halt and illegal reporting
module mc_datapath_p import mc_pkg::*; #(
  parameter int              WIDTH    = 16,
  parameter int              NREG     = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] pc_out,
  output logic             halted,
  output logic             illegal
);
  localparam int RW = $clog2(NREG);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, a_q, b_q, alu_q, mdr_q;
  logic [15:0]      ir_q;
  logic             z_q, c_q, ill_q, wb_q;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [3:0]       op;
  logic [RW-1:0]    rs, rt, rd, rf_wa;
  logic [1:0]       cond;
  logic [WIDTH-1:0] imm6, imm9, alu_b, alu_y, rd_rs, rd_rt, rf_wd;
  logic             alu_z, alu_c, is_r, is_mem_or_addi, legal, cond_ok, rf_we;
  assign op    = ir_q[15:12];
  assign rs    = ir_q[9+:RW];
  assign rt    = ir_q[6+:RW];
  assign rd    = ir_q[3+:RW];
  assign cond  = ir_q[1:0];
  assign imm6  = {{(WIDTH-6){ir_q[5]}}, ir_q[5:0]};
  assign imm9  = {{(WIDTH-9){ir_q[8]}}, ir_q[8:0]};
  assign is_r  = is_rtype(op);
  assign is_mem_or_addi = op == OP_ADDI || op == OP_LW || op == OP_SW;
  assign legal = is_r || is_mem_or_addi || op == OP_BEQ || op == OP_JAL || op == OP_HALT;
  assign rd_rs = rs == '0 ? '0 : regs_q[rs];
  assign rd_rt = rt == '0 ? '0 : regs_q[rt];
  assign alu_b = is_r ? b_q : imm6;
  assign cond_ok = cond == COND_AL || (cond == COND_Z && z_q) ||
                   (cond == COND_C && c_q) || (cond == COND_NZ && !z_q);
  mc_alu #(.WIDTH(WIDTH)) u_alu (
    .a(a_q), .b(alu_b), .aluop(is_r ? op[2:0] : ALU_ADD),
    .result(alu_y), .zero(alu_z), .carry(alu_c)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:           state_d = S_FETCH;
      S_FETCH:         state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:        state_d = op == OP_HALT ? S_HALT : !legal ? S_FETCH : S_EXEC;
      S_EXEC:          state_d = (is_r || op == OP_ADDI) ? S_ALUWB : op == OP_LW ? S_MEMRD :
                                 op == OP_SW ? S_MEMWR : S_FETCH;
      S_ALUWB, S_MEMWB: state_d = S_FETCH;
      S_MEMRD:         state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:         state_d = mem_ready ? S_FETCH : S_MEMWR;
      default:         state_d = S_HALT;
    endcase
  end
  always_comb begin
    rf_we = state_q == S_MEMWB || (state_q == S_EXEC && op == OP_JAL) ||
            (state_q == S_ALUWB && (!is_r || wb_q));
    rf_wa = state_q == S_EXEC ? rs : (state_q == S_ALUWB && is_r) ? rd : rt;
    rf_wd = state_q == S_EXEC ? pc_q : state_q == S_ALUWB ? alu_q : mdr_q;
  end
  // wb_q latches the condition against the flags that preceded this instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      ill_q   <= 1'b0;
      wb_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (rf_we && rf_wa != '0) regs_q[rf_wa] <= rf_wd;
      case (state_q)
        S_FETCH: if (mem_ready) begin
          ir_q <= mem_rdata[15:0];
          pc_q <= pc_q + WIDTH'(2);
        end
        S_DECODE: begin
          a_q   <= rd_rs;
          b_q   <= rd_rt;
          alu_q <= pc_q + ((op == OP_JAL ? imm9 : imm6) << 1);
          ill_q <= ill_q | ~legal;
        end
        S_EXEC: begin
          if (is_r) begin
            alu_q <= alu_y;
            z_q   <= alu_z;
            c_q   <= alu_c;
            wb_q  <= cond_ok;
          end else if (is_mem_or_addi) alu_q <= alu_y;
          if ((op == OP_BEQ && a_q == b_q) || op == OP_JAL) pc_q <= alu_q;
        end
        S_MEMRD: if (mem_ready) mdr_q <= mem_rdata;
        default: ;
      endcase
    end
  end
  assign mem_req   = state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR;
  assign mem_we    = state_q == S_MEMWR;
  assign mem_addr  = state_q == S_FETCH ? pc_q : alu_q;
  assign mem_wdata = b_q;
  assign pc_out    = pc_q;
  assign halted    = state_q == S_HALT;
  assign illegal   = ill_q;
endmodule
